n1_mem_arb: RTL and testbench
=============================

N1_MEM_ARB -- requirements
Module: N1_mem_arb

Interface
REQ-001 Parameter AW, default 16, address width in cells.
REQ-002 Parameter MAX_OUTST, default 2, maximum accepted-but-unacknowledged target accesses (1..7).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  module clock, all state updates on rising edge.
REQ-005 sync_rst_i  input  1  synchronous active-high reset.
REQ-006 pbus_cyc_i  input  1  program bus (fetch, read-only) cycle request.
REQ-007 pbus_stb_i  input  1  program bus access strobe.
REQ-008 pbus_adr_i  input  AW  program bus address.
REQ-009 pbus_dat_o  output  16  program bus read data.
REQ-010 pbus_ack_o  output  1  program bus acknowledge.
REQ-011 pbus_err_o  output  1  program bus error.
REQ-012 pbus_stall_o  output  1  program bus stall.
REQ-013 dbus_cyc_i  input  1  data bus cycle request.
REQ-014 dbus_stb_i  input  1  data bus access strobe.
REQ-015 dbus_we_i  input  1  data bus write enable.
REQ-016 dbus_adr_i  input  AW  data bus address.
REQ-017 dbus_dat_i  input  16  data bus write data.
REQ-018 dbus_dat_o  output  16  data bus read data.
REQ-019 dbus_ack_o  output  1  data bus acknowledge.
REQ-020 dbus_err_o  output  1  data bus error.
REQ-021 dbus_stall_o  output  1  data bus stall.
REQ-022 tgt_cyc_o  output  1  shared target cycle.
REQ-023 tgt_stb_o  output  1  shared target strobe.
REQ-024 tgt_we_o  output  1  shared target write enable.
REQ-025 tgt_adr_o  output  AW  shared target address.
REQ-026 tgt_dat_o  output  16  shared target write data.
REQ-027 tgt_dat_i  input  16  shared target read data.
REQ-028 tgt_ack_i / tgt_err_i / tgt_stall_i  input  1 each  target ack, error, stall.
REQ-029 prb_arb_state_o  output  2  state probe (IDLE=00, PBUS=01, DBUS=10).

Function
REQ-030 All buses SHALL follow pipelined Wishbone; outputs combinational from registered state and current inputs.
REQ-031 Registered state: FSM {IDLE, PBUS, DBUS}, outstanding counter cnt (width clog2(MAX_OUTST+1)), last_grant bit.
REQ-032 IDLE: tgt_cyc_o=0, tgt_stb_o=0, both stalls=1; if exactly one cyc_i high, enter its state next cycle; if both high, enter the one not equal to last_grant.
REQ-033 PBUS/DBUS: tgt_cyc_o = granted cyc_i; tgt_stb_o = granted stb_i & (cnt<MAX_OUTST); tgt_adr_o/tgt_dat_o from granted bus; tgt_we_o = 0 in PBUS, dbus_we_i in DBUS.
REQ-034 Granted stall_o = tgt_stall_i | (cnt==MAX_OUTST); non-granted stall_o = 1.
REQ-035 tgt_ack_i/tgt_err_i SHALL route only to the granted bus; both dat_o = tgt_dat_i; non-granted ack/err = 0.
REQ-036 cnt +1 on accept (tgt_stb_o & ~tgt_stall_i), -1 on ack or err, unchanged on both; saturate at 0 (spurious ack ignored).
REQ-037 Granted cyc_i low: set last_grant to current grant, clear cnt, next state = other bus state if its cyc_i high, else IDLE (zero-cycle handover).
REQ-038 Acks/errors arriving in IDLE or for a released grant SHALL be discarded.
REQ-039 Error SHALL NOT change grant; the initiator decides to drop cyc.

Reset
REQ-040 sync_rst_i high SHALL, at next edge, force IDLE, cnt=0, last_grant=DBUS, regardless of ongoing access; resulting outputs tgt_cyc_o=0, tgt_stb_o=0, all ack/err=0, both stalls=1.

Verification
REQ-041 pbus_cyc/stb=1, adr=0x0100 -> PBUS next cycle, tgt_stb_o=1, tgt_adr_o=0x0100, tgt_we_o=0; tgt_ack_i with tgt_dat_i=0xABCD -> pbus_ack_o=1, pbus_dat_o=0xABCD, dbus_ack_o=0.
REQ-042 Both cyc high after reset -> PBUS granted; pbus_cyc drops -> DBUS the following cycle, IDLE never visited; repeat tie -> PBUS.
REQ-043 MAX_OUTST=2, tgt_stall_i=0, no acks, three strobes -> third stalled, pbus_stall_o=1, cnt=2; ack plus new accept same cycle -> cnt stays 2.
REQ-044 DBUS write 0x1234 to 0x0020 with tgt_err_i -> dbus_err_o=1 one cycle, pbus_err_o=0, state stays DBUS.
REQ-045 Reset asserted in DBUS with cnt=2 -> IDLE, cnt=0, tgt_cyc_o=0 next cycle; late tgt_ack_i -> no ack on either bus.

Source files
------------

// File: rtl/n1_mem_arb_if.sv
// Pipelined Wishbone link between an initiator (master) and a responder (slave).
// dat_w carries initiator write data, dat_r carries responder read data.
interface n1_mem_arb_if #(
    parameter int AW = 16
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [15:0]   dat_w;
    logic [15:0]   dat_r;
    logic          ack;
    logic          err;
    logic          stall;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/n1_mem_arb.sv
// Two-initiator arbiter (program fetch bus, data bus) onto one pipelined Wishbone
// target, with a cap on accepted-but-unacknowledged accesses.
//
// state | meaning
// IDLE  | no grant; both initiators stalled, target cycle low
// PBUS  | program bus owns the target (read-only)
// DBUS  | data bus owns the target
module n1_mem_arb #(
    parameter int AW        = 16,
    parameter int MAX_OUTST = 2
) (
    input  logic               clk_i,
    input  logic               sync_rst_i,
    n1_mem_arb_if.slave        pbus,
    n1_mem_arb_if.slave        dbus,
    n1_mem_arb_if.master       tgt,
    output logic [1:0]         prb_arb_state_o
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PBUS = 2'b01,
        DBUS = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;  // 1 = data bus held it last

    logic          g_cyc, g_stb, g_we;
    logic [AW-1:0] g_adr;
    logic [15:0]   g_dat;
    logic          full, accept, done;

    // The program bus is fetch-only, so its write enable and write data are ignored.
    wire unused_pbus = &{1'b0, pbus.we, pbus.dat_w};

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        case (state_q)
            PBUS: begin
                g_cyc = pbus.cyc;
                g_stb = pbus.stb;
                g_adr = pbus.adr;
            end
            DBUS: begin
                g_cyc = dbus.cyc;
                g_stb = dbus.stb;
                g_we  = dbus.we;
                g_adr = dbus.adr;
                g_dat = dbus.dat_w;
            end
            default: ;
        endcase
    end

    assign full      = (cnt_q == CNT_MAX);
    assign tgt.cyc   = g_cyc;
    assign tgt.stb   = g_cyc & g_stb & ~full;
    assign tgt.we    = g_we;
    assign tgt.adr   = g_adr;
    assign tgt.dat_w = g_dat;

    assign accept = tgt.stb & ~tgt.stall;
    // Responses only count while a grant is live; in IDLE g_cyc is low so they drop.
    assign done   = g_cyc & (tgt.ack | tgt.err);

    assign pbus.stall = (state_q == PBUS) ? (tgt.stall | full) : 1'b1;
    assign dbus.stall = (state_q == DBUS) ? (tgt.stall | full) : 1'b1;
    assign pbus.ack   = (state_q == PBUS) & pbus.cyc & tgt.ack;
    assign pbus.err   = (state_q == PBUS) & pbus.cyc & tgt.err;
    assign dbus.ack   = (state_q == DBUS) & dbus.cyc & tgt.ack;
    assign dbus.err   = (state_q == DBUS) & dbus.cyc & tgt.err;
    assign pbus.dat_r = tgt.dat_r;
    assign dbus.dat_r = tgt.dat_r;

    assign prb_arb_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;

        if (accept && !done) begin
            cnt_d = cnt_q + CW'(1);
        end else if (done && !accept && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (pbus.cyc && dbus.cyc) begin
                    state_d = last_grant_q ? PBUS : DBUS;
                end else if (pbus.cyc) begin
                    state_d = PBUS;
                end else if (dbus.cyc) begin
                    state_d = DBUS;
                end
            end
            PBUS: begin
                if (!pbus.cyc) begin
                    last_grant_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = dbus.cyc ? DBUS : IDLE;
                end
            end
            DBUS: begin
                if (!dbus.cyc) begin
                    last_grant_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = pbus.cyc ? PBUS : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: tb/tb_n1_mem_arb.sv
// Directed bench for n1_mem_arb: the driver queues a hand-computed output snapshot
// per cycle, a negedge monitor pops and compares it with the live DUT outputs.
module tb_n1_mem_arb;
    typedef struct packed {
        logic [1:0]  st;
        logic        tcyc;
        logic        tstb;
        logic        twe;
        logic [15:0] tadr;
        logic [15:0] tdat;
        logic        pack;
        logic        perr;
        logic        pstall;
        logic        dack;
        logic        derr;
        logic        dstall;
        logic [15:0] pdat;
        logic [15:0] ddat;
    } snap_t;

    logic        clk;
    logic        rst;
    logic [1:0]  st_probe;
    logic        p_cyc, p_stb;
    logic [15:0] p_adr;
    logic        d_cyc, d_stb, d_we;
    logic [15:0] d_adr, d_dat;
    logic [15:0] t_dat;
    logic        t_ack, t_err, t_stall;

    snap_t exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    n1_mem_arb_if #(.AW(16)) pbus ();
    n1_mem_arb_if #(.AW(16)) dbus ();
    n1_mem_arb_if #(.AW(16)) tgt ();

    assign pbus.cyc   = p_cyc;
    assign pbus.stb   = p_stb;
    assign pbus.we    = 1'b0;
    assign pbus.adr   = p_adr;
    assign pbus.dat_w = 16'h0000;
    assign dbus.cyc   = d_cyc;
    assign dbus.stb   = d_stb;
    assign dbus.we    = d_we;
    assign dbus.adr   = d_adr;
    assign dbus.dat_w = d_dat;
    assign tgt.dat_r  = t_dat;
    assign tgt.ack    = t_ack;
    assign tgt.err    = t_err;
    assign tgt.stall  = t_stall;

    n1_mem_arb #(.AW(16), .MAX_OUTST(2)) dut (
        .clk_i           (clk),
        .sync_rst_i      (rst),
        .pbus            (pbus),
        .dbus            (dbus),
        .tgt             (tgt),
        .prb_arb_state_o (st_probe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        snap_t e, a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.st     = st_probe;
            a.tcyc   = tgt.cyc;
            a.tstb   = tgt.stb;
            a.twe    = tgt.we;
            a.tadr   = tgt.adr;
            a.tdat   = tgt.dat_w;
            a.pack   = pbus.ack;
            a.perr   = pbus.err;
            a.pstall = pbus.stall;
            a.dack   = dbus.ack;
            a.derr   = dbus.err;
            a.dstall = dbus.stall;
            a.pdat   = pbus.dat_r;
            a.ddat   = dbus.dat_r;
            if (!e.tcyc) begin
                a.tadr = '0; e.tadr = '0;
                a.twe  = 1'b0; e.twe = 1'b0;
            end
            if (!(e.tcyc && e.twe)) begin
                a.tdat = '0; e.tdat = '0;
            end
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got %h, expected %h (st %b/%b)", n, a, e, a.st, e.st);
            end
        end
    end

    task automatic step(input string nm, input logic [1:0] st, input logic tcyc, input logic tstb,
                        input logic twe, input logic [15:0] tadr, input logic [15:0] tdat,
                        input logic pack, input logic perr, input logic pstall,
                        input logic dack, input logic derr, input logic dstall);
        snap_t e;
        e.st = st; e.tcyc = tcyc; e.tstb = tstb; e.twe = twe; e.tadr = tadr; e.tdat = tdat;
        e.pack = pack; e.perr = perr; e.pstall = pstall;
        e.dack = dack; e.derr = derr; e.dstall = dstall;
        e.pdat = t_dat; e.ddat = t_dat;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 2'd0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        p_cyc = 0; p_stb = 0; p_adr = 16'h0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_adr = 16'h0; d_dat = 16'h0;
        t_dat = 16'h0; t_ack = 0; t_err = 0; t_stall = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle("reset");

        // single program fetch with read data
        p_cyc = 1; p_stb = 1; p_adr = 16'h0100;
        idle("t1_idle");
        step("t1_req", 2'd1, 1, 1, 0, 16'h0100, 16'h0, 0, 0, 0, 0, 0, 1);
        p_stb = 0; t_ack = 1; t_dat = 16'hABCD;
        step("t1_ack", 2'd1, 1, 0, 0, 16'h0100, 16'h0, 1, 0, 0, 0, 0, 1);
        t_ack = 0; p_cyc = 0;
        step("t1_rel", 2'd1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1);
        idle("t1_idle2");

        // tie-break after reset and zero-cycle handover
        rst = 1;
        idle("t2_rst");
        rst = 0;
        p_cyc = 1; d_cyc = 1; p_adr = 16'h0200; d_adr = 16'h0300;
        idle("t2_tie_idle");
        step("t2_pgrant", 2'd1, 1, 0, 0, 16'h0200, 16'h0, 0, 0, 0, 0, 0, 1);
        p_cyc = 0;
        step("t2_prel", 2'd1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1);
        step("t2_dgrant", 2'd2, 1, 0, 0, 16'h0300, 16'h0, 0, 0, 1, 0, 0, 0);
        d_cyc = 0;
        step("t2_drel", 2'd2, 0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);
        idle("t2_idle");
        p_cyc = 1; d_cyc = 1;
        idle("t2_tie2_idle");
        step("t2_pgrant2", 2'd1, 1, 0, 0, 16'h0200, 16'h0, 0, 0, 0, 0, 0, 1);
        p_cyc = 0; d_cyc = 0;
        step("t2_prel2", 2'd1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 1);
        idle("t2_idle2");

        // outstanding limit, ack+accept, spurious ack saturation
        p_cyc = 1; p_stb = 1; p_adr = 16'h0400;
        idle("t3_idle");
        step("t3_acc1", 2'd1, 1, 1, 0, 16'h0400, 16'h0, 0, 0, 0, 0, 0, 1);
        p_adr = 16'h0401;
        step("t3_acc2", 2'd1, 1, 1, 0, 16'h0401, 16'h0, 0, 0, 0, 0, 0, 1);
        p_adr = 16'h0402;
        step("t3_full", 2'd1, 1, 0, 0, 16'h0402, 16'h0, 0, 0, 1, 0, 0, 1);
        t_ack = 1;
        step("t3_ack_full", 2'd1, 1, 0, 0, 16'h0402, 16'h0, 1, 0, 1, 0, 0, 1);
        step("t3_ack_acc", 2'd1, 1, 1, 0, 16'h0402, 16'h0, 1, 0, 0, 0, 0, 1);
        t_ack = 0; p_adr = 16'h0403;
        step("t3_acc3", 2'd1, 1, 1, 0, 16'h0403, 16'h0, 0, 0, 0, 0, 0, 1);
        step("t3_full2", 2'd1, 1, 0, 0, 16'h0403, 16'h0, 0, 0, 1, 0, 0, 1);
        p_stb = 0; t_ack = 1;
        step("t3_drain1", 2'd1, 1, 0, 0, 16'h0403, 16'h0, 1, 0, 1, 0, 0, 1);
        step("t3_drain2", 2'd1, 1, 0, 0, 16'h0403, 16'h0, 1, 0, 0, 0, 0, 1);
        step("t3_spurious", 2'd1, 1, 0, 0, 16'h0403, 16'h0, 1, 0, 0, 0, 0, 1);
        t_ack = 0; p_stb = 1;
        step("t3_acc4", 2'd1, 1, 1, 0, 16'h0403, 16'h0, 0, 0, 0, 0, 0, 1);
        step("t3_acc5", 2'd1, 1, 1, 0, 16'h0403, 16'h0, 0, 0, 0, 0, 0, 1);
        step("t3_full3", 2'd1, 1, 0, 0, 16'h0403, 16'h0, 0, 0, 1, 0, 0, 1);
        p_cyc = 0; p_stb = 0;
        step("t3_rel", 2'd1, 0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 1);
        idle("t3_idle2");
        p_cyc = 1; d_cyc = 1;
        idle("t3_tie_idle");
        step("t3_tie_dgrant", 2'd2, 1, 0, 0, 16'h0300, 16'h0, 0, 0, 1, 0, 0, 0);
        p_cyc = 0; d_cyc = 0;
        step("t3_tie_rel", 2'd2, 0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);
        idle("t3_idle3");

        // data write with target stall then error
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 16'h0020; d_dat = 16'h1234; t_stall = 1;
        idle("t4_idle");
        step("t4_stalled", 2'd2, 1, 1, 1, 16'h0020, 16'h1234, 0, 0, 1, 0, 0, 1);
        t_stall = 0;
        step("t4_acc", 2'd2, 1, 1, 1, 16'h0020, 16'h1234, 0, 0, 1, 0, 0, 0);
        d_stb = 0; t_err = 1;
        step("t4_err", 2'd2, 1, 0, 1, 16'h0020, 16'h1234, 0, 0, 1, 0, 1, 0);
        t_err = 0;
        step("t4_after", 2'd2, 1, 0, 1, 16'h0020, 16'h1234, 0, 0, 1, 0, 0, 0);
        d_cyc = 0; d_we = 0;
        step("t4_rel", 2'd2, 0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 0);
        idle("t4_idle2");

        // reset while data bus is full, late ack discarded
        d_cyc = 1; d_stb = 1; d_adr = 16'h0030;
        idle("t5_idle");
        step("t5_acc1", 2'd2, 1, 1, 0, 16'h0030, 16'h0, 0, 0, 1, 0, 0, 0);
        step("t5_acc2", 2'd2, 1, 1, 0, 16'h0030, 16'h0, 0, 0, 1, 0, 0, 0);
        rst = 1;
        step("t5_rst_full", 2'd2, 1, 0, 0, 16'h0030, 16'h0, 0, 0, 1, 0, 0, 1);
        rst = 0; t_ack = 1;
        idle("t5_late_ack");
        t_ack = 0;
        step("t5_regrant", 2'd2, 1, 1, 0, 16'h0030, 16'h0, 0, 0, 1, 0, 0, 0);
        step("t5_acc2b", 2'd2, 1, 1, 0, 16'h0030, 16'h0, 0, 0, 1, 0, 0, 0);
        step("t5_full", 2'd2, 1, 0, 0, 16'h0030, 16'h0, 0, 0, 1, 0, 0, 1);
        d_cyc = 0; d_stb = 0;
        step("t5_rel", 2'd2, 0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 0, 0, 1);
        idle("t5_end");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
